// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch sequencer.
//            Holds the FSM state encoding, instruction/PC constants and a
//            small PC alignment helper used by the top level.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ZERO_INSTR = 32'h0000_0000;

  // HALT is only reachable when IMEM_FETCH_HALT_ON_ZERO_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl_if
// Purpose  : Bundles the instruction memory port, the redirect input and the
//            decode-side valid/ready fetch port of imem_fetch_ctrl.
// Ports    : imem_addr/imem_instr        - instruction memory address/data
//            redirect_valid/redirect_pc  - branch/jump redirect request
//            fetch_valid/ready/instr/pc  - decode handshake and payload
//            fetch_misaligned            - sticky misaligned-target flag
//            busy                        - controller is actively fetching
// Modports : master - the fetch controller
//            slave  - the environment (memory, branch unit, decode)
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if;
  import fetch_pkg::*;

  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               fetch_valid;
  logic               fetch_ready;
  logic [INSTR_W-1:0] fetch_instr;
  logic [31:0]        fetch_pc;
  logic               fetch_misaligned;
  logic               busy;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_valid,
    input  fetch_ready,
    output fetch_instr,
    output fetch_pc,
    output fetch_misaligned,
    output busy
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  fetch_valid,
    output fetch_ready,
    input  fetch_instr,
    input  fetch_pc,
    input  fetch_misaligned,
    input  busy
  );

endinterface : imem_fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small circular prefetch FIFO holding {pc, instruction} pairs.
//            Flush has priority over push and pop. Push while full is only
//            accepted when a pop happens on the same edge.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            push, push_data     - write request and data at the tail
//            pop                 - consume the head entry
//            flush               - discard all entries
//            head_data           - entry at the head (don't-care when empty)
//            full, empty         - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 2 * INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic do_push;
  logic do_pop;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop && !empty;
  // A full FIFO can still take a new entry if the head leaves on this edge.
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so pointer increments wrap at DEPTH naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are qualified by count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction fetch sequencer. Owns the PC, drives the memory
//            address every cycle, captures {pc, instr} into a prefetch FIFO
//            presented to decode, and flushes on branch/jump redirects.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - imem_fetch_ctrl_if.master (memory, redirect, decode)
// Options  : IMEM_FETCH_HALT_ON_ZERO_EN - when defined, fetching an all-zero
//            word stops further fetch (HALT) until the next redirect.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  imem_fetch_ctrl_if.master   bus
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         misaligned_q;
  logic         busy_q;

  logic         fifo_full;
  logic         fifo_empty;
  logic [2*INSTR_W-1:0] head_data;

  logic         pop;
  logic         redirect_take;
  logic         push;
  logic         fifo_pop;
  logic         halt_hit;

  // Redirects are ignored while IDLE; elsewhere they override everything.
  assign redirect_take = bus.redirect_valid && (state_q != IDLE);
  assign pop           = !fifo_empty && bus.fetch_ready;
  assign push          = (state_q == RUN) && !redirect_take && (!fifo_full || pop);
  // A pop coinciding with a redirect is dropped along with the flush.
  assign fifo_pop      = pop && !redirect_take;

`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
  assign halt_hit = push && (bus.imem_instr == ZERO_INSTR);
`else
  assign halt_hit = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (fifo_pop),
    .flush     (redirect_take),
    .push_data ({pc_q, bus.imem_instr}),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Control FSM; busy is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: begin
          if (halt_hit) begin
            state_q <= HALT;
            busy_q  <= 1'b0;
          end
        end
`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
        HALT: begin
          if (redirect_take) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Program counter: redirect beats sequential advance; holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_take) begin
      pc_q <= align_pc(bus.redirect_pc);
    end else if (push) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  // Sticky until reset so software can observe any bad target after the fact.
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else if (redirect_take && (bus.redirect_pc[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end

  assign bus.imem_addr        = pc_q;
  assign bus.fetch_valid      = !fifo_empty;
  assign bus.fetch_pc         = head_data[2*INSTR_W-1:INSTR_W];
  assign bus.fetch_instr      = head_data[INSTR_W-1:0];
  assign bus.fetch_misaligned = misaligned_q;
  assign bus.busy             = busy_q;

endmodule : imem_fetch_ctrl
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Self-checking bench for imem_fetch_ctrl. Directed scenarios for
//            startup, backpressure, redirect, misalignment and reset, then
//            randomized traffic against a queue-based reference model.
// Options  : IMEM_FETCH_HALT_ON_ZERO_EN - enables the halt scenario/model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus();

  logic [31:0] mem [64];
  assign bus.imem_instr = mem[bus.imem_addr[7:2]];

  imem_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of {pc, instr} pairs plus a few flags.
  logic [63:0] m_q [$];
  logic [31:0] m_pc   = RESET_PC;
  bit          m_run  = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_mis  = 1'b0;

  task automatic model_edge();
    int          n;
    bit          popd;
    logic [31:0] w;
    if (rst) begin
      m_q.delete();
      m_pc   = RESET_PC;
      m_run  = 1'b0;
      m_halt = 1'b0;
      m_mis  = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (bus.redirect_valid) begin
      m_q.delete();
      m_pc   = {bus.redirect_pc[31:2], 2'b00};
      m_halt = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      n    = m_q.size();
      popd = (n > 0) && bus.fetch_ready;
      if (popd) void'(m_q.pop_front());
      if (!m_halt && ((n < DEPTH) || popd)) begin
        w = mem[m_pc[7:2]];
        m_q.push_back({m_pc, w});
        m_pc = m_pc + 32'd4;
`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
        if (w == 32'h0) m_halt = 1'b1;
`endif
      end
    end
  endtask

  task automatic model_cmp();
    chk("valid", bus.fetch_valid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("head_pc", bus.fetch_pc, m_q[0][63:32]);
      chk("head_instr", bus.fetch_instr, m_q[0][31:0]);
    end
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("misaligned", bus.fetch_misaligned, m_mis);
    chk("busy", bus.busy, (m_run && !m_halt));
  endtask

  // One clock: inputs are already set; update model at the edge, check after.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin : main
    bit found;

    for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h00A0_0113;
    mem[2]  = 32'h0020_81B3;
    mem[10] = 32'h0630_0493;
    mem[11] = 32'h0010_A533;
    mem[12] = 32'h0000_0000;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.fetch_ready    = 1'b1;

    // Startup stream with decode always ready.
    do_reset();
    chk("rst_valid", bus.fetch_valid, 0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_busy", bus.busy, 0);
    cyc();
    cyc();
    chk("s1_pc0", bus.fetch_pc, 32'h0);
    chk("s1_in0", bus.fetch_instr, 32'h0050_0093);
    cyc();
    chk("s1_pc1", bus.fetch_pc, 32'h4);
    chk("s1_in1", bus.fetch_instr, 32'h00A0_0113);
    cyc();
    chk("s1_pc2", bus.fetch_pc, 32'h8);
    chk("s1_in2", bus.fetch_instr, 32'h0020_81B3);

    // Backpressure: FIFO fills, PC stalls, then drains without gaps.
    bus.fetch_ready = 1'b0;
    do_reset();
    repeat (5) cyc();
    chk("s2_addr", bus.imem_addr, 32'h8);
    chk("s2_hold_pc", bus.fetch_pc, 32'h0);
    chk("s2_hold_in", bus.fetch_instr, 32'h0050_0093);
    bus.fetch_ready = 1'b1;
    chk("s2_d0", bus.fetch_pc, 32'h0);
    cyc();
    chk("s2_d1", bus.fetch_pc, 32'h4);
    cyc();
    chk("s2_d2", bus.fetch_pc, 32'h8);
    chk("s2_d2v", bus.fetch_valid, 1);

    // Redirect while FIFO holds 0x10, 0x14.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.fetch_valid && bus.fetch_pc == 32'h10) begin
        found = 1'b1;
        break;
      end
    end
    chk("s3_seek", found, 1);
    bus.fetch_ready = 1'b0;
    cyc();
    chk("s3_addr", bus.imem_addr, 32'h18);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h28;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("s3_flush", bus.fetch_valid, 0);
    cyc();
    chk("s3_t_pc", bus.fetch_pc, 32'h28);
    chk("s3_t_in", bus.fetch_instr, 32'h0630_0493);
    bus.fetch_ready = 1'b1;
    cyc();
    chk("s3_n_pc", bus.fetch_pc, 32'h2C);
    chk("s3_n_in", bus.fetch_instr, 32'h0010_A533);

    // Misaligned target.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2A;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("s4_mis", bus.fetch_misaligned, 1);
    cyc();
    chk("s4_pc", bus.fetch_pc, 32'h28);
    repeat (3) cyc();
    chk("s4_sticky", bus.fetch_misaligned, 1);

    // Reset with the FIFO full.
    bus.fetch_ready = 1'b0;
    repeat (3) cyc();
    chk("s5_full", bus.fetch_valid, 1);
    rst = 1'b1;
    cyc();
    chk("s5_valid", bus.fetch_valid, 0);
    chk("s5_addr", bus.imem_addr, RESET_PC);
    chk("s5_mis", bus.fetch_misaligned, 0);
    rst = 1'b0;

`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
    // Zero word at 0x30 is delivered, then fetch stops until a redirect.
    bus.fetch_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (bus.fetch_valid && bus.fetch_pc == 32'h30 && bus.fetch_instr == 32'h0) found = 1'b1;
    end
    chk("s6_zero", found, 1);
    chk("s6_busy", bus.busy, 0);
    chk("s6_valid", bus.fetch_valid, 0);
    chk("s6_addr", bus.imem_addr, 32'h34);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    cyc();
    bus.redirect_valid = 1'b0;
    cyc();
    chk("s6_pc", bus.fetch_pc, 32'h0);
    chk("s6_in", bus.fetch_instr, 32'h0050_0093);
    chk("s6_run", bus.busy, 1);
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.fetch_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = $urandom;
      if ($urandom_range(0, 3) != 0) bus.redirect_pc[31:8] = 24'h0;
      if ($urandom_range(0, 3) != 0) bus.redirect_pc[1:0] = 2'b00;
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imem_fetch_ctrl
`default_nettype wire
